// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n} and
// arbiter state encodings with aliases for bench-side ASCII decode.
package sdram_pkg;

  localparam logic [3:0] CMD_LMR       = 4'b0000;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_BSTOP     = 4'b0110;
  localparam logic [3:0] CMD_NOP       = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

  localparam logic [2:0] ARB_IDLE  = 3'd0;
  localparam logic [2:0] ARB_ARBIT = 3'd1;
  localparam logic [2:0] ARB_AREF  = 3'd2;
  localparam logic [2:0] ARB_WRITE = 3'd3;
  localparam logic [2:0] ARB_READ  = 3'd4;

  // Five-character ASCII tag for a raw state code, handy in waveform viewers.
  function automatic logic [39:0] arb_state_ascii(input logic [2:0] s);
    case (s)
      ARB_IDLE:  arb_state_ascii = "IDLE ";
      ARB_ARBIT: arb_state_ascii = "ARBIT";
      ARB_AREF:  arb_state_ascii = "AREF ";
      ARB_WRITE: arb_state_ascii = "WRITE";
      ARB_READ:  arb_state_ascii = "READ ";
      default:   arb_state_ascii = "?????";
    endcase
  endfunction

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: grants init/refresh/write/read sequencers in turn.
// Optional macro SDRAM_ARB_RR_EN enables round-robin between write and read.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DQ_W   = 16
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic              wr_sdram_en,
  input  logic [3:0]        wr_sdram_cmd,
  input  logic [1:0]        wr_sdram_bank,
  input  logic [ADDR_W-1:0] wr_sdram_addr,
  input  logic [DQ_W-1:0]   wr_sdram_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_sdram_cmd,
  input  logic [1:0]        rd_sdram_bank,
  input  logic [ADDR_W-1:0] rd_sdram_addr,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  arb_state_e state_q, state_d;
  logic       aref_en_q, wr_en_q, rd_en_q;
  logic       wr_wins;

`ifdef SDRAM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  // Flag remembers which burst type was served last (1 = write).
  assign wr_wins = ~rr_last_q;

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == ST_ARBIT && state_d == ST_WRITE) rr_last_d = 1'b1;
    if (state_q == ST_ARBIT && state_d == ST_READ)  rr_last_d = 1'b0;
  end

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) rr_last_q <= 1'b0;
    else         rr_last_q <= rr_last_d;
  end
`else
  assign wr_wins = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)                           state_d = ST_AREF;
        else if (wr_req && (!rd_req || wr_wins)) state_d = ST_WRITE;
        else if (rd_req)                        state_d = ST_READ;
      end
      ST_AREF:  if (aref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
      ST_READ:  if (rd_end)   state_d = ST_ARBIT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grants are registered from the next state so they track state_q exactly.
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state_q   <= ST_IDLE;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= (state_d == ST_AREF);
      wr_en_q   <= (state_d == ST_WRITE);
      rd_en_q   <= (state_d == ST_READ);
    end
  end

  assign aref_en = aref_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;

  logic [3:0]        cmd_mux;
  logic [1:0]        bank_mux;
  logic [ADDR_W-1:0] addr_mux;

  always_comb begin
    cmd_mux  = CMD_NOP;
    bank_mux = 2'd0;
    addr_mux = '0;
    unique case (state_q)
      ST_IDLE:  begin cmd_mux = init_cmd;     bank_mux = init_bank;     addr_mux = init_addr;     end
      ST_AREF:  begin cmd_mux = aref_cmd;     bank_mux = aref_bank;     addr_mux = aref_addr;     end
      ST_WRITE: begin cmd_mux = wr_sdram_cmd; bank_mux = wr_sdram_bank; addr_mux = wr_sdram_addr; end
      ST_READ:  begin cmd_mux = rd_sdram_cmd; bank_mux = rd_sdram_bank; addr_mux = rd_sdram_addr; end
      default:  ;
    endcase
  end

  assign sdram_cke   = 1'b1;
  assign sdram_cs_n  = cmd_mux[3];
  assign sdram_ras_n = cmd_mux[2];
  assign sdram_cas_n = cmd_mux[1];
  assign sdram_we_n  = cmd_mux[0];
  assign sdram_bank  = bank_mux;
  assign sdram_addr  = addr_mux;
  assign sdram_dq    = (state_q == ST_WRITE && wr_sdram_en) ? wr_sdram_data : {DQ_W{1'bz}};

endmodule
